decode_stage_ctrl: RTL

//  Decode-stage sequencer sitting between fetch and execute; it feeds the immediate generator.

---
 rtl/dstage_pkg.sv | 25 ++
 rtl/imm_sel_decode.sv | 23 ++
 rtl/decode_stage_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/dstage_pkg.sv
// Shared decode-stage constants: immediate-select codes, RV32 opcodes, bubble encoding, FSM states.
package dstage_pkg;
  localparam logic [2:0] IMM_S      = 3'd0;
  localparam logic [2:0] IMM_B      = 3'd1;
  localparam logic [2:0] IMM_U      = 3'd2;
  localparam logic [2:0] IMM_J      = 3'd3;
  localparam logic [2:0] IMM_I      = 3'd4;
  localparam logic [2:0] IMM_I_STAR = 3'd5;
  localparam logic [2:0] IMM_CSR    = 3'd6;
  localparam logic [2:0] IMM_NONE   = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;
endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode/funct3 -> immediate-select decode; shared with the hazard unit.
module imm_sel_decode
  import dstage_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_imm_sel
);
  always_comb begin
    o_imm_sel = IMM_NONE;
    case (i_opcode)
      OPC_LOAD, OPC_JALR:  o_imm_sel = IMM_I;
      OPC_STORE:           o_imm_sel = IMM_S;
      OPC_BRANCH:          o_imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:  o_imm_sel = IMM_U;
      OPC_JAL:             o_imm_sel = IMM_J;
      OPC_OPIMM:           o_imm_sel = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? IMM_I_STAR : IMM_I;
      // funct3[2]=1 are the immediate CSR forms; every other SYSTEM funct3 uses the I slot
      OPC_SYSTEM:          o_imm_sel = i_funct3[2] ? IMM_CSR : IMM_I;
      default:             o_imm_sel = IMM_NONE;
    endcase
  end
endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode-stage sequencer: single-entry pipeline register between fetch and execute,
// with flush, execute back-pressure and a CSR drain window.
module decode_stage_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] NOP_INST     = dstage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [31:0]     f_inst,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_ready,
  input  logic            x_ready,
  input  logic            x_flush,
  output logic            d_valid,
  output logic [31:0]     d_inst,
  output logic [XLEN-1:0] d_pc,
  output logic [2:0]      d_imm_sel,
  output logic            d_csr_busy
);
  import dstage_pkg::*;

  localparam int unsigned CNT_W_RAW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [31:0]       r_inst;
  logic [XLEN-1:0]   r_pc;
  logic [2:0]        r_imm_sel;

  logic [2:0]        w_imm_sel;
  logic              w_accept;
  logic              w_is_csr;

  imm_sel_decode u_dec (
    .i_opcode  (f_inst[6:0]),
    .i_funct3  (f_inst[14:12]),
    .o_imm_sel (w_imm_sel)
  );

  assign f_ready  = (r_state == ST_RUN) && (!r_valid || x_ready) && !x_flush;
  assign w_accept = f_valid && f_ready;
  assign w_is_csr = (f_inst[6:0] == OPC_SYSTEM) && (f_inst[14:12] != 3'b000) && (DRAIN_CYCLES > 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_inst    <= NOP_INST;
      r_pc      <= '0;
      r_imm_sel <= IMM_I;
    end else if (x_flush) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_inst    <= NOP_INST;
      r_imm_sel <= IMM_I;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_inst    <= f_inst;
            r_pc      <= f_pc;
            r_imm_sel <= w_imm_sel;
            if (w_is_csr) begin
              // entry is parked invisible to execute until the drain window closes
              r_state <= ST_DRAIN;
              r_cnt   <= CNT_INIT;
              r_valid <= 1'b0;
            end else begin
              r_valid <= 1'b1;
            end
          end else if (x_ready && r_valid) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign d_valid    = r_valid;
  assign d_inst     = r_inst;
  assign d_pc       = r_pc;
  assign d_imm_sel  = r_imm_sel;
  assign d_csr_busy = (r_state == ST_DRAIN);
endmodule
